// File: rtl/sq_wave_generator.sv
// Free-running quadrature square-wave source: two 50 % duty outputs a quarter period apart.
// Optional simulation-only protocol checker enabled by defining SQW_CHECK_EN.
`timescale 1ns/1ps
module sq_wave_generator #(
  parameter int QUARTER_CYCLES = 1,
  parameter bit B_LEADS        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  output logic sq_a,
  output logic sq_b
);

  localparam int PRE_W = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(QUARTER_CYCLES - 1);

  // Encodings equal the {sq_a,sq_b} pattern so the outputs come straight off the phase flops.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  phase_t           phase;
  phase_t           phase_next;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_next;
  logic             step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre   <= '0;
      phase <= PH_00;
    end else begin
      pre   <= pre_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    step       = (pre == PRE_LAST);
    pre_next   = step ? '0 : pre + PRE_W'(1);
    phase_next = phase;
    if (step) begin
      if (B_LEADS) begin
        unique case (phase)
          PH_00:   phase_next = PH_01;
          PH_01:   phase_next = PH_11;
          PH_11:   phase_next = PH_10;
          PH_10:   phase_next = PH_00;
          default: phase_next = PH_00;
        endcase
      end else begin
        unique case (phase)
          PH_00:   phase_next = PH_10;
          PH_10:   phase_next = PH_11;
          PH_11:   phase_next = PH_01;
          PH_01:   phase_next = PH_00;
          default: phase_next = PH_00;
        endcase
      end
    end
  end

  always_comb begin
    {sq_a, sq_b} = phase;
  end

`ifdef SQW_CHECK_EN
  if (QUARTER_CYCLES < 1) begin : g_bad_cfg
    $fatal(1, "sq_wave_generator: QUARTER_CYCLES must be >= 1");
  end

  function automatic logic [1:0] chk_succ(input logic [1:0] cur);
    logic [1:0] nxt;
    if (B_LEADS) begin
      case (cur)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (cur)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

  logic [1:0] chk_prev;
  int         chk_gap;
  logic       chk_seen;

  // Outputs are observed one edge late; edge spacing is unaffected by the constant offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_prev <= 2'b00;
      chk_gap  <= 0;
      chk_seen <= 1'b0;
    end else begin
      if ({sq_a, sq_b} != chk_prev) begin
        if ((sq_a != chk_prev[1]) && (sq_b != chk_prev[0]))
          $error("sq_wave_generator: both outputs changed on the same edge");
        if (chk_seen && (chk_gap != QUARTER_CYCLES))
          $error("sq_wave_generator: edge spacing %0d, expected %0d", chk_gap, QUARTER_CYCLES);
        if ({sq_a, sq_b} != chk_succ(chk_prev))
          $error("sq_wave_generator: illegal phase transition %b -> %b", chk_prev, {sq_a, sq_b});
        chk_gap  <= 1;
        chk_seen <= 1'b1;
      end else if (chk_gap <= QUARTER_CYCLES) begin
        chk_gap <= chk_gap + 1;
      end
      chk_prev <= {sq_a, sq_b};
    end
  end
`endif

endmodule

// File: tb/tb_sq_wave_generator.sv
// Self-checking bench for sq_wave_generator: four configurations against an edge-count reference model.
`timescale 1ns/1ps
module tb_sq_wave_generator;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic a0, b0, a1, b1, a2, b2, a3, b3;
  logic [1:0] obs [4];

  int unsigned qc [4] = '{1, 3, 1, 5};
  bit          bl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  int errors = 0;
  int checks = 0;
  longint unsigned n;

  sq_wave_generator u0 (.clk(clk), .reset(reset), .sq_a(a0), .sq_b(b0));
  sq_wave_generator #(.QUARTER_CYCLES(3)) u1 (.clk(clk), .reset(reset), .sq_a(a1), .sq_b(b1));
  sq_wave_generator #(.B_LEADS(1'b1)) u2 (.clk(clk), .reset(reset), .sq_a(a2), .sq_b(b2));
  sq_wave_generator #(.QUARTER_CYCLES(5), .B_LEADS(1'b1)) u3 (.clk(clk), .reset(reset), .sq_a(a3), .sq_b(b3));

  assign obs[0] = {a0, b0};
  assign obs[1] = {a1, b1};
  assign obs[2] = {a2, b2};
  assign obs[3] = {a3, b3};

  always #125 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Step index = edges / quarter; the leading channel is high on steps 1,2 and the lagging on 2,3.
  function automatic logic [1:0] model(input int unsigned q, input bit b_leads, input longint unsigned edges);
    longint unsigned s;
    logic lead, lag;
    s    = (edges / q) % 4;
    lead = (s == 1) || (s == 2);
    lag  = (s == 2) || (s == 3);
    return b_leads ? {lag, lead} : {lead, lag};
  endfunction

  task automatic test_reset();
    for (int unsigned t = 0; t < 2; t++) begin
      #(t == 0 ? 200 : 250);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== 2'b00) begin
          errors++;
          $display("FAIL reset_hold dut%0d t=%0t got=%b exp=00", k, $time, obs[k]);
        end
      end
    end
    #(500 - $time);
    reset = 1'b0;
  endtask

  task automatic test_release_timing();
    int unsigned t_tab [8] = '{626, 876, 1126, 1376, 1626, 1876, 2626, 3376};
    logic [1:0] e0 [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00};
    logic [1:0] e1 [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] e2 [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 8; i++) begin
      #(t_tab[i] - $time);
      checks++;
      if (obs[0] !== e0[i]) begin
        errors++;
        $display("FAIL release_default t=%0t got=%b exp=%b", $time, obs[0], e0[i]);
      end
      checks++;
      if (obs[1] !== e1[i]) begin
        errors++;
        $display("FAIL release_quarter3 t=%0t got=%b exp=%b", $time, obs[1], e1[i]);
      end
      checks++;
      if (obs[2] !== e2[i]) begin
        errors++;
        $display("FAIL release_b_leads t=%0t got=%b exp=%b", $time, obs[2], e2[i]);
      end
    end
  endtask

  task automatic test_sequence();
    while ($time < 5200) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== model(qc[k], bl[k], n)) begin
          errors++;
          $display("FAIL sequence dut%0d t=%0t got=%b exp=%b", k, $time, obs[k], model(qc[k], bl[k], n));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    #(5500 - $time);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 2'b00) begin
        errors++;
        $display("FAIL async_reset dut%0d t=%0t got=%b exp=00", k, $time, obs[k]);
      end
    end
    #400;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs[k] !== 2'b00) begin
        errors++;
        $display("FAIL async_reset_hold dut%0d t=%0t got=%b exp=00", k, $time, obs[k]);
      end
    end
    #(6500 - $time);
    reset = 1'b0;
    #(6626 - $time);
    checks++;
    if (obs[0] !== 2'b10) begin
      errors++;
      $display("FAIL rerelease_a t=%0t got=%b exp=10", $time, obs[0]);
    end
    #250;
    checks++;
    if (obs[0] !== 2'b11) begin
      errors++;
      $display("FAIL rerelease_b t=%0t got=%b exp=11", $time, obs[0]);
    end
  endtask

  task automatic test_random_resets();
    int unsigned d;
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(10, 250)) begin
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (obs[k] !== model(qc[k], bl[k], n)) begin
            errors++;
            $display("FAIL random_run dut%0d it=%0d t=%0t got=%b exp=%b", k, it, $time, obs[k], model(qc[k], bl[k], n));
          end
        end
      end
      d = $urandom_range(1, 240);
      if (d == 124) d = 123;
      #(d);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== 2'b00) begin
          errors++;
          $display("FAIL random_reset dut%0d it=%0d t=%0t got=%b exp=00", k, it, $time, obs[k]);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(5, 100));
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_release_timing();
    test_sequence();
    test_async_reset();
    test_random_resets();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
